// File: rtl/flipflop_bist_if.sv
// Connection bundle between the flip-flop BIST controller and the cell it
// exercises, plus the start/status handshake to the test controller.
interface flipflop_bist_if #(
   parameter int NUM_VECTORS = 16,
   parameter int ERR_W       = 8
);
   localparam int VEC_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;

   logic             start;
   logic             dut_d;
   logic             dut_reset;
   logic             dut_q;
   logic             dut_q_bar;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_count;
   logic [VEC_W-1:0] vec_index;

   // BIST side: drives stimulus and status, observes the cell
   modport master (
      input  start, dut_q, dut_q_bar,
      output dut_d, dut_reset, busy, done, pass, err_count, vec_index
   );

   // Cell / test-controller side
   modport slave (
      output start, dut_q, dut_q_bar,
      input  dut_d, dut_reset, busy, done, pass, err_count, vec_index
   );
endinterface

// File: rtl/flipflop_bist.sv
// Self-test controller for a single-bit D flip-flop cell. Drives d/reset
// vectors, samples q/q_bar at the last edge of each vector and keeps a
// saturating error count.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | cell held in reset, waiting for start
//   S_INIT | cell held in reset for HOLD cycles, then q==0 check
//   S_RUN  | vectors 0..NUM_VECTORS-1, HOLD cycles each, checked at end
//   S_DONE | result frozen, cell held in reset, start restarts
module flipflop_bist #(
   parameter int NUM_VECTORS = 16,
   parameter int HOLD        = 2,
   parameter int RST_START   = 8,
   parameter int RST_LEN     = 4,
   parameter int ERR_W       = 8
) (
   input  logic             clock,
   input  logic             reset,
   flipflop_bist_if.master  bus
);
   localparam int VEC_W  = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
   localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [VEC_W-1:0]  LAST_VEC  = VEC_W'(NUM_VECTORS - 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD - 1);

   typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;

   state_t            state, state_n;
   logic [HOLD_W-1:0] hold_cnt, hold_n;
   logic [VEC_W-1:0]  vec, vec_n;
   logic [ERR_W-1:0]  err, err_n;
   logic              d_r, d_n;
   logic              dres_r, dres_n;
   logic              exp_q;
   logic [1:0]        inc;

   // Window test naturally truncates when the window runs past the last vector
   function automatic logic in_window(input int k);
      return (k >= RST_START) && (k < RST_START + RST_LEN);
   endfunction

   function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a,
                                                 input logic [1:0] b);
      logic [ERR_W:0] s;
      s = {1'b0, a} + (ERR_W+1)'(b);
      return s[ERR_W] ? {ERR_W{1'b1}} : s[ERR_W-1:0];
   endfunction

   // State and stimulus registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         hold_cnt <= '0;
         vec      <= '0;
         err      <= '0;
         d_r      <= 1'b0;
         dres_r   <= 1'b1;
      end else begin
         state    <= state_n;
         hold_cnt <= hold_n;
         vec      <= vec_n;
         err      <= err_n;
         d_r      <= d_n;
         dres_r   <= dres_n;
      end
   end

   // Next-state, vector sequencing and check logic
   always_comb begin
      state_n = state;
      hold_n  = hold_cnt;
      vec_n   = vec;
      err_n   = err;
      d_n     = d_r;
      dres_n  = dres_r;
      exp_q   = dres_r ? 1'b0 : vec[0];
      inc     = {1'b0, (bus.dut_q != exp_q)} + {1'b0, (bus.dut_q_bar == bus.dut_q)};
      case (state)
         S_IDLE, S_DONE: begin
            d_n    = 1'b0;
            dres_n = 1'b1;
            if (bus.start) begin
               state_n = S_INIT;
               err_n   = '0;
               vec_n   = '0;
               hold_n  = HOLD_LOAD;
            end
         end
         S_INIT: begin
            if (hold_cnt == '0) begin
               if (bus.dut_q != 1'b0 || bus.dut_q_bar != 1'b1)
                  err_n = sat_add(err, 2'd1);
               state_n = S_RUN;
               vec_n   = '0;
               d_n     = 1'b0;
               dres_n  = in_window(0);
               hold_n  = HOLD_LOAD;
            end else begin
               hold_n = hold_cnt - 1'b1;
            end
         end
         S_RUN: begin
            if (hold_cnt == '0) begin
               err_n = sat_add(err, inc);
               if (vec == LAST_VEC) begin
                  state_n = S_DONE;
                  d_n     = 1'b0;
                  dres_n  = 1'b1;
               end else begin
                  vec_n  = vec + 1'b1;
                  d_n    = vec_n[0];
                  dres_n = in_window(int'(vec) + 1);
                  hold_n = HOLD_LOAD;
               end
            end else begin
               hold_n = hold_cnt - 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign bus.dut_d     = d_r;
   assign bus.dut_reset = dres_r;
   assign bus.busy      = (state == S_INIT) || (state == S_RUN);
   assign bus.done      = (state == S_DONE);
   assign bus.pass      = (state == S_DONE) && (err == '0);
   assign bus.err_count = err;
   assign bus.vec_index = vec;
endmodule

// File: doc/flipflop_bist.md
Name: flipflop_bist

Overview:
Built-in self-test controller for the single-bit D flip-flop cell (d, clock, reset, q, q_bar). It is the driving and checking end of that cell's interface. It generates the d/reset stimulus, samples q and q_bar, compares them against an internal reference model, and reports pass/fail with a saturating error count. It sits next to each flip-flop instance under test and is started by a one-cycle pulse from the test controller.

Parameters:
NUM_VECTORS, 16, number of stimulus vectors per run (>=2)
HOLD, 2, clock cycles each vector is held (>=2)
RST_START, 8, index of first vector during which dut_reset is asserted
RST_LEN, 4, number of consecutive vectors with dut_reset asserted (0 = none)
ERR_W, 8, error counter width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset of the BIST itself
start  in  1  one-cycle start request, sampled in IDLE and DONE only
dut_d  out  1  registered d stimulus to the flip-flop under test
dut_reset  out  1  registered reset stimulus to the flip-flop under test (active-high)
dut_q  in  1  q from the flip-flop under test
dut_q_bar  in  1  q_bar from the flip-flop under test
busy  out  1  high from the cycle after start is accepted until done rises
done  out  1  high from run completion until the next accepted start or reset
pass  out  1  done && err_count==0
err_count  out  ERR_W  saturating count of failed checks in the current or last run
vec_index  out  clog2(NUM_VECTORS)  index of the vector currently driven

Behaviour:
- Reset (async, reset=1): state=IDLE, dut_d=0, dut_reset=1, busy=0, done=0, pass=0, err_count=0, vec_index=0, hold counter=0.
- States: IDLE, INIT, RUN, DONE.
- IDLE: dut_reset=1, dut_d=0. On start=1: go to INIT, clear err_count, busy=1.
- INIT: lasts HOLD cycles with dut_reset=1, dut_d=0. At the final INIT edge:
  - check dut_q==0 and dut_q_bar==1;
  - a failure adds 1 to err_count;
  - load vector 0 and go to RUN.
- RUN, vector k:
  - dut_d = k[0], so d toggles every vector and vector 0 has d=0.
  - dut_reset = 1 iff RST_START <= k < RST_START+RST_LEN; otherwise 0.
  - Both signals are registered and change only at a vector boundary edge.
  - Each vector lasts exactly HOLD cycles.
- Check at each vector's final edge, which is also the edge that loads vector k+1:
  - expected_q = 0 if vector k asserted dut_reset, otherwise k[0];
  - check 1: dut_q == expected_q;
  - check 2: dut_q_bar == ~dut_q;
  - each failing check adds 1, so 0, 1 or 2 is added per vector.
- Latency: dut_d is updated at edge E0, the DUT captures it at E1, and the BIST samples at E_HOLD (>=E2). HOLD>=2 guarantees settling whether the DUT reset is synchronous or asynchronous.
- After the final-edge check of vector NUM_VECTORS-1:
  - go to DONE with dut_reset=1, dut_d=0;
  - busy=0, done=1;
  - pass valid in the same cycle as done.
- DONE: holds err_count and pass. On start=1: clear done/pass/err_count and enter INIT (restart).
- start while busy (INIT/RUN): ignored, with no effect on the sequence.
- err_count saturates at 2^ERR_W-1 and never wraps.
- vec_index tracks the vector being driven; it is 0 in IDLE/INIT and holds NUM_VECTORS-1 in DONE.
- reset asserted mid-run: immediate return to IDLE values, and the partial result is discarded.
- RST_START+RST_LEN > NUM_VECTORS: the reset window is truncated at the last vector.
- dut_q/dut_q_bar are sampled only at check edges; values between checks are don't-care.

Test Plan:
- Correct DUT flip-flop attached, defaults, start pulse: busy for 2+16*2=34 cycles, then done=1, pass=1, err_count=0. The dut_d waveform is 0,1,0,1,… and dut_reset is high for vectors 8–11.
- Forced dut_q stuck-at-1 (dut_q_bar=~dut_q): fails the INIT check (1) plus every vector expecting q=0 (vectors 0,2,4,6,12,14 give 6, vectors 8–11 give 4). Result: err_count=11, pass=0.
- dut_q_bar tied equal to dut_q with correct q: 1 (INIT) + 16 errors, so err_count=17, pass=0.
- ERR_W=3 with dut_q stuck-at-1 and dut_q_bar stuck-at-1: err_count saturates at 7 and stays 7 at done.
- Assert reset at vector 5 of a run: all outputs are at reset values in the same cycle (dut_reset=1, busy=0). A new start then completes a full clean run with pass=1.
- start pulses during RUN are ignored, with no extra cycles. A start in DONE restarts: done falls, busy rises, err_count clears, and the run completes again with identical timing.
